// File: rtl/ats21_pkg.sv
// Shared ATS21 constants and types, used by the timer core and by the alarm queue.
package ats21_pkg;

    localparam int NUM_ALARMS = 24;
    localparam int ALARM_ID_W = $clog2(NUM_ALARMS);

    typedef logic [ALARM_ID_W-1:0] alarm_id_t;
    typedef logic [NUM_ALARMS-1:0] alarm_mask_t;

    // Returns a one-hot mask for an in-range ID, or all zeros for an out-of-range ID.
    function automatic alarm_mask_t id_to_mask(alarm_id_t id);
        alarm_mask_t mask;
        mask = '0;
        if (int'(id) < NUM_ALARMS) begin
            mask[id] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/ats21_event_fifo.sv
// In-order event FIFO. A push and a pop may happen in the same cycle, including when the FIFO is full.
module ats21_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The head reads as zero when the FIFO is empty, so stale data never leaks out.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ats21_alarm_queue.sv
// Turns each ATS21 alarm expiry into one queued alarm-ID event for the host.
// Also keeps a sticky per-alarm pending mask and an overflow flag.
module ats21_alarm_queue
    import ats21_pkg::*;
#(
    parameter int NUM_ALARMS = ats21_pkg::NUM_ALARMS,
    parameter int DEPTH      = 8,
    parameter int ID_W       = $clog2(NUM_ALARMS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_ALARMS-1:0]     alarm_data,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [ID_W-1:0]           evt_id,
    output logic [$clog2(DEPTH):0]    evt_count,
    output logic [NUM_ALARMS-1:0]     pending,
    input  logic                      clr_req,
    input  logic [ID_W-1:0]           clr_id,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    logic [NUM_ALARMS-1:0] prev;
    logic [NUM_ALARMS-1:0] arm;
    logic [NUM_ALARMS-1:0] rise;
    logic [NUM_ALARMS-1:0] push_mask;
    logic [NUM_ALARMS-1:0] clr_mask;
    logic [ID_W-1:0]       sel_id;
    logic                  have_arm;
    logic                  push;
    logic                  pop;
    logic                  coalesce;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign rise = alarm_data & ~prev;
    assign pop  = evt_valid && evt_ready;

    // Lowest-index armed alarm wins.
    always_comb begin
        sel_id   = '0;
        have_arm = 1'b0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (arm[i]) begin
                sel_id   = ID_W'(i);
                have_arm = 1'b1;
            end
        end
    end

    // When the FIFO is full, a same-cycle pop frees the slot for this push.
    assign push = have_arm && (!fifo_full || pop);

    always_comb begin
        push_mask = '0;
        if (push) begin
            push_mask[sel_id] = 1'b1;
        end
    end

    always_comb begin
        clr_mask = '0;
        if (clr_req && (int'(clr_id) < NUM_ALARMS)) begin
            clr_mask[clr_id] = 1'b1;
        end
    end

    // A rise on a bit being pushed this cycle re-arms it and is not counted as coalesced.
    assign coalesce = |(rise & arm & ~push_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev     <= '0;
            arm      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            prev     <= alarm_data;
            arm      <= (arm & ~push_mask) | rise;
            pending  <= (pending & ~clr_mask) | rise;
            overflow <= coalesce | (overflow & ~ovf_clr);
        end
    end

    ats21_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (sel_id),
        .pop       (pop),
        .head      (evt_id),
        .count     (evt_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_ats21_alarm_queue.sv
// Scoreboard bench for ats21_alarm_queue: a queue-based reference model predicts enqueued IDs and register state.
module tb_ats21_alarm_queue;

    localparam int NA    = 24;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] alarm_data;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_id;
    logic [3:0]  evt_count;
    logic [23:0] pending;
    logic        clr_req;
    logic [4:0]  clr_id;
    logic        overflow;
    logic        ovf_clr;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_fifo[$];
    int          exp_q[$];
    logic [23:0] m_arm;
    logic [23:0] m_prev;
    logic [23:0] m_pend;
    logic        m_ovf;

    ats21_alarm_queue #(.NUM_ALARMS(NA), .DEPTH(DEPTH), .ID_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .alarm_data (alarm_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .evt_count  (evt_count),
        .pending    (pending),
        .clr_req    (clr_req),
        .clr_id     (clr_id),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_arm  = '0;
        m_prev = '0;
        m_pend = '0;
        m_ovf  = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs held across that edge.
    task automatic model_step();
        logic [23:0] rise;
        int          sel;
        bit          do_pop;
        bit          coal;
        rise   = alarm_data & ~m_prev;
        do_pop = (m_fifo.size() > 0) && evt_ready;
        sel    = -1;
        for (int k = 0; k < NA; k++) begin
            if (m_arm[k] && sel < 0) sel = k;
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (sel >= 0 && m_fifo.size() < DEPTH) begin
            m_fifo.push_back(sel);
            exp_q.push_back(sel);
            m_arm[sel] = 1'b0;
        end
        coal = 0;
        for (int k = 0; k < NA; k++) begin
            if (rise[k]) begin
                if (m_arm[k]) coal = 1;
                m_arm[k] = 1'b1;
            end
        end
        if (clr_req && clr_id < NA) m_pend[clr_id] = 1'b0;
        m_pend = m_pend | rise;
        if (ovf_clr) m_ovf = 1'b0;
        if (coal) m_ovf = 1'b1;
        m_prev = alarm_data;
    endtask

    task automatic check_outputs();
        chk("evt_valid", 32'(evt_valid), 32'(m_fifo.size() != 0));
        chk("evt_count", 32'(evt_count), 32'(m_fifo.size()));
        chk("evt_id",    32'(evt_id),    (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
        chk("pending",   32'(pending),   32'(m_pend));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    task automatic cyc(input logic [23:0] d, input logic rdy, input logic cr = 1'b0,
                       input logic [4:0] cid = 5'd0, input logic oc = 1'b0, input logic rst = 1'b1);
        alarm_data = d;
        evt_ready  = rdy;
        clr_req    = cr;
        clr_id     = cid;
        ovf_clr    = oc;
        reset      = rst;
        if (!rst) model_reset();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    // Monitor: every accepted handshake must match the next predicted ID.
    always @(negedge clk) begin
        if (reset === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(evt_id), 32'hFFFF_FFFF);
            end else begin
                chk("event_order", 32'(evt_id), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [23:0] rd;
        model_reset();
        cyc('0, 1'b0, .rst(1'b0));
        cyc('0, 1'b0, .rst(1'b0));
        chk("reset_valid", 32'(evt_valid), 32'd0);
        chk("reset_count", 32'(evt_count), 32'd0);
        cyc('0, 1'b1);

        // Single expiry on bit 5
        cyc(24'h000020, 1'b1);
        chk("single_pending5", 32'(pending[5]), 32'd1);
        chk("single_not_yet", 32'(evt_valid), 32'd0);
        cyc(24'h000020, 1'b1);
        chk("single_valid", 32'(evt_valid), 32'd1);
        chk("single_id", 32'(evt_id), 32'd5);
        repeat (4) cyc('0, 1'b1);
        chk("single_ovf", 32'(overflow), 32'd0);
        chk("single_drained", 32'(exp_q.size()), 32'd0);

        // Simultaneous expiries 0, 3, 17 with host stalled
        repeat (2) cyc(24'h020009, 1'b0);
        repeat (3) cyc('0, 1'b0);
        chk("simul_count", 32'(evt_count), 32'd3);
        chk("simul_head", 32'(evt_id), 32'd0);
        repeat (5) cyc('0, 1'b1);

        // Backpressure: 10 alarms into an 8-deep FIFO
        repeat (2) cyc(24'h0FFC00, 1'b0);
        repeat (12) cyc('0, 1'b0);
        chk("bp_count", 32'(evt_count), 32'd8);
        chk("bp_ovf", 32'(overflow), 32'd0);
        repeat (14) cyc('0, 1'b1);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Coalesce: alarm 2 fires twice while the FIFO is full
        repeat (2) cyc(24'h03FC00, 1'b0);
        repeat (10) cyc('0, 1'b0);
        repeat (2) cyc(24'h000004, 1'b0);
        repeat (2) cyc('0, 1'b0);
        chk("coal_before", 32'(overflow), 32'd0);
        repeat (2) cyc(24'h000004, 1'b0);
        chk("coal_ovf", 32'(overflow), 32'd1);
        cyc('0, 1'b0, .oc(1'b1));
        chk("coal_ovf_clr", 32'(overflow), 32'd0);
        repeat (14) cyc('0, 1'b1);
        chk("coal_drained", 32'(exp_q.size()), 32'd0);

        // Pending clear collision and out-of-range clear
        cyc(24'h000080, 1'b1, 1'b1, 5'd7);
        chk("clr_collide", 32'(pending[7]), 32'd1);
        cyc(24'h000080, 1'b1, 1'b1, 5'd30);
        chk("clr_oob", 32'(pending[7]), 32'd1);
        cyc('0, 1'b1, 1'b1, 5'd7);
        chk("clr_done", 32'(pending[7]), 32'd0);
        repeat (3) cyc('0, 1'b1);

        // Reset mid-operation with alarm 9 held high
        repeat (2) cyc(24'h000152, 1'b0);
        repeat (4) cyc('0, 1'b0);
        chk("rst_pre_count", 32'(evt_count), 32'd4);
        cyc(24'h000200, 1'b0, .rst(1'b0));
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        cyc(24'h000200, 1'b0, .rst(1'b0));
        repeat (2) cyc(24'h000200, 1'b0);
        chk("rst_one_event", 32'(evt_count), 32'd1);
        chk("rst_id9", 32'(evt_id), 32'd9);
        repeat (3) cyc('0, 1'b1);
        chk("rst_drained", 32'(exp_q.size()), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            rd = 24'($urandom() & $urandom() & $urandom() & $urandom());
            cyc(rd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 15) == 0));
        end
        repeat (60) cyc('0, 1'b1);
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("final_arm_empty", 32'(m_arm), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
